mod_addsub_serial: RTL and testbench

Word-serial modular adder/subtractor: returns (opA + opB) mod opM or (opA − opB) mod opM for operands up to DATA_WIDTH bits, processing WORD_WIDTH bits per cycle. It is the multi-cycle, handshaked successor to the single-cycle combinational modular adder in the modular arithmetic library. It trades latency for a short carry chain so that 256-bit and wider field operations close timing in the ECC point-arithmetic datapath.

---
 rtl/mod_addsub_serial.sv | 170 +++++++++++++++++
 tb/tb_mod_addsub_serial.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mod_addsub_serial.sv
// Word-serial modular adder/subtractor: (A +/- B) mod M, WORD_WIDTH bits per cycle.
// Optional operand range flag enabled by defining MOD_ADDSUB_RANGE_CHECK_EN.
module mod_addsub_serial #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned WORD_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [DATA_WIDTH-1:0] opA,
  input  logic [DATA_WIDTH-1:0] opB,
  input  logic [DATA_WIDTH-1:0] opM,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  range_err
);

  localparam int unsigned NW = DATA_WIDTH / WORD_WIDTH;
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;

  state_t                state_q, state_d;
  logic                  in_ready_d, out_valid_d;
  logic                  accept_c;
  logic                  last_word_c;

  logic [DATA_WIDTH-1:0] a_q, b_q, m_q, s_q, t_q;
  logic                  op_sub_q;
  logic [CW-1:0]         cnt_q;
  logic                  carry_q;
  logic                  flag1_q;   // add: carry out of A+B; sub: borrow out of A-B
  logic                  flag2_q;   // carry out of s + ~M + 1 (i.e. no borrow in s-M)

  logic [WORD_WIDTH-1:0] x_w, y_raw, y_w;
  logic [WORD_WIDTH:0]   sum_full;
  logic                  invert_c;
  logic                  use_t_c;

  assign accept_c    = (state_q == IDLE) && in_valid && in_ready;
  assign last_word_c = (cnt_q == CW'(NW - 1));

  // State register and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: if (accept_c) state_d = PH1;
      PH1:  if (last_word_c) state_d = PH2;
      PH2:  if (last_word_c) state_d = DONE;
      DONE: if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_q == DONE) && (state_d == DONE);
  end

  // Per-word operand select: PH1 uses A and B, PH2 uses s and M
  always_comb begin
    x_w   = '0;
    y_raw = '0;
    for (int i = 0; i < int'(NW); i++) begin
      if (cnt_q == CW'(i)) begin
        x_w   = (state_q == PH2) ? s_q[i*WORD_WIDTH +: WORD_WIDTH] : a_q[i*WORD_WIDTH +: WORD_WIDTH];
        y_raw = (state_q == PH2) ? m_q[i*WORD_WIDTH +: WORD_WIDTH] : b_q[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Subtraction is done as add of the one's complement with carry-in 1
  assign invert_c = (state_q == PH2) ? ~op_sub_q : op_sub_q;
  assign y_w      = invert_c ? ~y_raw : y_raw;
  assign sum_full = {1'b0, x_w} + {1'b0, y_w} + {{WORD_WIDTH{1'b0}}, carry_q};

  // Add picks t when A+B overflowed or s >= M; subtract picks t when A-B borrowed
  assign use_t_c = op_sub_q ? flag1_q : (flag1_q | flag2_q);

  // Operand capture and word-serial datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      s_q      <= '0;
      t_q      <= '0;
      op_sub_q <= 1'b0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      flag1_q  <= 1'b0;
      flag2_q  <= 1'b0;
      out_data <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            a_q      <= opA;
            b_q      <= opB;
            m_q      <= opM;
            op_sub_q <= op_sub;
            cnt_q    <= '0;
            carry_q  <= op_sub;
            flag1_q  <= 1'b0;
            flag2_q  <= 1'b0;
          end
        end
        PH1: begin
          for (int i = 0; i < int'(NW); i++) begin
            if (cnt_q == CW'(i)) s_q[i*WORD_WIDTH +: WORD_WIDTH] <= sum_full[WORD_WIDTH-1:0];
          end
          if (last_word_c) begin
            cnt_q   <= '0;
            carry_q <= ~op_sub_q;
            flag1_q <= op_sub_q ? ~sum_full[WORD_WIDTH] : sum_full[WORD_WIDTH];
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            carry_q <= sum_full[WORD_WIDTH];
          end
        end
        PH2: begin
          for (int i = 0; i < int'(NW); i++) begin
            if (cnt_q == CW'(i)) t_q[i*WORD_WIDTH +: WORD_WIDTH] <= sum_full[WORD_WIDTH-1:0];
          end
          if (last_word_c) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            flag2_q <= sum_full[WORD_WIDTH];
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            carry_q <= sum_full[WORD_WIDTH];
          end
        end
        DONE: begin
          if (!out_valid) out_data <= use_t_c ? t_q : s_q;
        end
        default: ;
      endcase
    end
  end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  // Range flag captured at accept, held until the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      range_err <= 1'b0;
    end else if (accept_c) begin
      range_err <= (opA >= opM) || (opB >= opM);
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_addsub_serial.sv
// Directed bench for mod_addsub_serial at DATA_WIDTH=16, WORD_WIDTH=4, M=0xFFF1.
module tb_mod_addsub_serial;

  localparam int unsigned DW = 16;
  localparam int unsigned WW = 4;
  localparam logic [DW-1:0] MOD = 16'hFFF1;

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  localparam logic RANGE_EXP = 1'b1;
`else
  localparam logic RANGE_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          op_sub;
  logic [DW-1:0] opA, opB, opM;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          range_err;

  int total = 0;
  int bad   = 0;

  mod_addsub_serial #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .opA(opA), .opB(opB), .opM(opM), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for its result
  task automatic run_op(input string tag, input logic sub, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_data,
                        input logic exp_range);
    int   n;
    logic saw_ready;
    op_sub   = sub;
    opA      = a;
    opB      = b;
    opM      = MOD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    opA      = '0;
    opB      = '0;
    n         = 0;
    saw_ready = 1'b0;
    while (!out_valid && n < 20) begin
      saw_ready = saw_ready | in_ready;
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd9);
    check({tag, "_busy"}, 32'(saw_ready), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_range"}, 32'(range_err), 32'(exp_range));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    opA       = '0;
    opB       = '0;
    opM       = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_range", 32'(range_err), 32'd0);

    // Additions: reduction, MSW carry-out, exact modulus
    run_op("add_red", 1'b0, 16'hFFF0, 16'h0005, 16'h0004, 1'b0);
    drain("add_red");
    run_op("add_carry", 1'b0, 16'hFFF0, 16'hFFF0, 16'hFFEF, 1'b0);
    drain("add_carry");
    run_op("add_eqm", 1'b0, 16'h8000, 16'h7FF1, 16'h0000, 1'b0);
    drain("add_eqm");

    // Subtractions: borrow, no borrow, equal operands
    run_op("sub_borrow", 1'b1, 16'h0003, 16'h0005, 16'hFFEF, 1'b0);
    drain("sub_borrow");
    run_op("sub_eq", 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b0);
    drain("sub_eq");
    run_op("sub_plain", 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b0);

    // Backpressure: hold result, ignore in_valid pulses
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2) == 0;
      tick();
      check("bp_data", 32'(out_data), 32'h0002);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    drain("bp");

    // Reset in the middle of PH2 discards the operation
    op_sub   = 1'b0;
    opA      = 16'h0100;
    opB      = 16'h0200;
    opM      = MOD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_data", 32'(out_data), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    run_op("fresh", 1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0);
    drain("fresh");

    // Range flag: out-of-range then in-range operands
    run_op("range_hi", 1'b0, 16'hFFF1, 16'h0000, 16'h0000, RANGE_EXP);
    drain("range_hi");
    run_op("range_ok", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
    drain("range_ok");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
